switch_egress_buffer: RTL
=========================

// Module: switch_egress_buffer
// PURPOSE
//  Per-port egress stage downstream of the 4-port switch output mux. Captures the switch's per-port
//  output {data_out, target_out, source_out, valid_out} into a DEPTH-entry FIFO, checks routing, and
//  drains packets to the port sink over a valid/ready handshake. One instance per switch output port.
// PARAMETERS
//  PORT_ID   0  index of the switch port this instance serves (0..ADDR_WIDTH-1)
//  DEPTH     4  FIFO entries, power of 2, >=2
// PORTS
//  clk            in   1           clock, all logic on rising edge
//  rst            in   1           asynchronous, active-high reset
//  sw_valid       in   1           switch output valid (port.valid_out)
//  sw_source      in   ADDR_WIDTH  source field, one-hot
//  sw_target      in   ADDR_WIDTH  target field, one-hot
//  sw_data        in   DATA_WIDTH  payload
//  out_valid      out  1           packet available to sink
//  out_ready      in   1           sink accepts when out_valid && out_ready
//  out_pkt        out  PKT_WIDTH   {data, target, source} (packet_t)
//  fifo_full      out  1           count == DEPTH
//  fifo_empty     out  1           count == 0 (output register excluded)
//  drop_pulse     out  1           1-cycle pulse: packet dropped (full or misroute)
//  misroute_pulse out  1           1-cycle pulse: sw_target != (1 << PORT_ID)
// BEHAVIOUR
//  Reset (async, rst=1): FIFO ptrs/count=0, out_valid=0, out_pkt=0, fifo_full=0, fifo_empty=1,
//   drop_pulse=0, misroute_pulse=0, stats counters=0, FSM=S_IDLE. Reset mid-packet discards all contents.
//  Push: on edge with sw_valid=1. Misroute (sw_target != 1<<PORT_ID, incl. zero/multi-hot) -> not
//   written, misroute_pulse=1 and drop_pulse=1 next cycle. Else written if !fifo_full || pop_this_cycle;
//   if full with no pop -> dropped, drop_pulse=1. Never backpressures the switch (switch has no ready).
//  Pop: pop_this_cycle = !fifo_empty && (!out_valid || out_ready); loads head into out_pkt register.
//  Output FSM, 2 states:
//   S_IDLE  (out_valid=0): pop -> S_VALID.
//   S_VALID (out_valid=1): out_ready && fifo_empty -> S_IDLE; out_ready && !fifo_empty -> S_VALID
//    with next packet (back-to-back, 1 pkt/cycle); !out_ready -> hold, out_pkt stable.
//  Latency: packet pushed into empty FIFO with idle output -> out_valid 2 edges after sw_valid
//   (edge 1 write, edge 2 pop). FIFO empty bypass is not permitted.
//  Simultaneous push+pop: count unchanged; at count==DEPTH, push accepted only because pop occurs.
//  Pointers log2(DEPTH) bits, wrap naturally; count log2(DEPTH)+1 bits, never exceeds DEPTH.
//  Ordering: strict FIFO; out_valid must not drop before handshake completes.
// CONFIGURATION
//  EGRESS_STATS_EN defined: adds outputs pkt_cnt, drop_cnt, misroute_cnt (each 16 bit); pkt_cnt
//   increments on each out_valid&&out_ready, drop_cnt on drop_pulse, misroute_cnt on misroute_pulse;
//   all saturate at 16'hFFFF, cleared by rst.
//  Not defined: those ports and counters absent; all other behaviour identical.
// STRUCTURE
//  packet_pkg additions: PKT_WIDTH = DATA_WIDTH + 2*ADDR_WIDTH; typedef struct packed
//   {data, target, source} packet_t; typedef enum logic {S_IDLE, S_VALID} egress_state_t.
//  One sub-module: egress_fifo (DEPTH-param storage, ptrs, count, full/empty; push/pop inputs).
//  FSM, routing check, pulses and stats stay in switch_egress_buffer.
// TESTING (PORT_ID=2 -> own target 4'b0100, DEPTH=4, out_ready=1 unless stated)
//  1 Single pkt: sw_valid 1 cycle, target 4'b0100, source 4'b0001, data 'hA5 -> out_valid 2 edges
//    later for 1 cycle, out_pkt={'hA5,4'b0100,4'b0001}; fifo_empty=1 after.
//  2 Misroute: target 4'b1000 -> misroute_pulse=1, drop_pulse=1 one cycle, out_valid never rises.
//  3 Overflow: out_ready=0, 6 valid pkts data 1..6 -> 1 in out reg, 4 in FIFO, fifo_full=1, pkt 6
//    dropped (drop_pulse); raise out_ready -> outputs 1,2,3,4,5 back-to-back in order.
//  4 Stall: out_ready toggled 1010... during 3-pkt stream -> each out_pkt held stable until accepted.
//  5 Push+pop at full: full, out_ready=1 and sw_valid same cycle -> new pkt accepted, no drop, count=4.
//  6 Reset mid-op: rst=1 with 3 pkts queued -> out_valid=0, fifo_empty=1 immediately (async);
//    with EGRESS_STATS_EN all counters 0.

Source files
------------

// File: rtl/switch_egress_buffer_pkg.sv
// Shared types and widths for the switch egress buffer.
// Optional statistics counters are enabled by defining EGRESS_STATS_EN.
package switch_egress_buffer_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH = 4;
  localparam int unsigned PKT_WIDTH  = DATA_WIDTH + 2 * ADDR_WIDTH;
  localparam int unsigned STAT_WIDTH = 16;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] source;
  } packet_t;

  typedef enum logic {
    S_IDLE,
    S_VALID
  } egress_state_t;

  // One-hot target code owned by a given switch port.
  function automatic logic [ADDR_WIDTH-1:0] port_onehot(input int unsigned id);
    return ADDR_WIDTH'(1) << id;
  endfunction

  // Saturating increment for statistics counters.
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (v == {STAT_WIDTH{1'b1}}) ? v : v + STAT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/switch_egress_buffer_if.sv
// Switch-side capture bus and sink-side valid/ready bus of the egress buffer.
interface switch_egress_buffer_if;
  import switch_egress_buffer_pkg::*;

  logic                  sw_valid;
  logic [ADDR_WIDTH-1:0] sw_source;
  logic [ADDR_WIDTH-1:0] sw_target;
  logic [DATA_WIDTH-1:0] sw_data;
  logic                  out_valid;
  logic                  out_ready;
  packet_t               out_pkt;

  modport master (
    output sw_valid, sw_source, sw_target, sw_data, out_ready,
    input  out_valid, out_pkt
  );

  modport slave (
    input  sw_valid, sw_source, sw_target, sw_data, out_ready,
    output out_valid, out_pkt
  );

endinterface

// File: rtl/switch_egress_buffer_fifo.sv
// Packet FIFO storage with pointers, occupancy count and registered full/empty flags.
module switch_egress_buffer_fifo
  import switch_egress_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  packet_t wr_data,
  output packet_t head_c,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  packet_t         mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_d;

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count;
    case ({push, pop})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: count_d = count;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_d;
      full  <= (count_d == CW'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  // Storage array, not reset: contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign head_c = mem[rd_ptr];

endmodule

// File: rtl/switch_egress_buffer.sv
// Per-port egress stage: captures switch output, checks routing, buffers and drains
// packets to the sink over valid/ready. Define EGRESS_STATS_EN to add saturating
// pkt/drop/misroute counters.
module switch_egress_buffer
  import switch_egress_buffer_pkg::*;
#(
  parameter int unsigned PORT_ID = 0,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  switch_egress_buffer_if.slave bus,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  drop_pulse,
  output logic                  misroute_pulse
`ifdef EGRESS_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] pkt_cnt,
  output logic [STAT_WIDTH-1:0] drop_cnt,
  output logic [STAT_WIDTH-1:0] misroute_cnt
`endif
);

  localparam logic [ADDR_WIDTH-1:0] OWN_TARGET = port_onehot(PORT_ID);

  egress_state_t state_q;
  egress_state_t state_d;
  packet_t       pkt_in;
  packet_t       head_c;
  logic          misroute_c;
  logic          overflow_c;
  logic          pop_c;
  logic          push_c;

  assign pkt_in = '{data: bus.sw_data, target: bus.sw_target, source: bus.sw_source};

  // Routing check and FIFO push/pop decisions; the switch is never backpressured.
  always_comb begin
    misroute_c = bus.sw_valid && (bus.sw_target != OWN_TARGET);
    pop_c      = !fifo_empty && (!bus.out_valid || bus.out_ready);
    push_c     = bus.sw_valid && !misroute_c && (!fifo_full || pop_c);
    overflow_c = bus.sw_valid && !misroute_c && fifo_full && !pop_c;
  end

  switch_egress_buffer_fifo #(
    .DEPTH (DEPTH)
  ) u_egress_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .pop     (pop_c),
    .wr_data (pkt_in),
    .head_c  (head_c),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Output FSM next state: a pop always leaves a packet presented.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pop_c) state_d = S_VALID;
      S_VALID: if (bus.out_ready && !pop_c) state_d = S_IDLE;
    endcase
  end

  // State, output register and event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      bus.out_valid  <= 1'b0;
      bus.out_pkt    <= '0;
      drop_pulse     <= 1'b0;
      misroute_pulse <= 1'b0;
    end else begin
      state_q        <= state_d;
      bus.out_valid  <= (state_d == S_VALID);
      if (pop_c) bus.out_pkt <= head_c;
      drop_pulse     <= misroute_c || overflow_c;
      misroute_pulse <= misroute_c;
    end
  end

`ifdef EGRESS_STATS_EN
  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt      <= '0;
      drop_cnt     <= '0;
      misroute_cnt <= '0;
    end else begin
      if (bus.out_valid && bus.out_ready) pkt_cnt <= sat_inc(pkt_cnt);
      if (drop_pulse)                     drop_cnt <= sat_inc(drop_cnt);
      if (misroute_pulse)                 misroute_cnt <= sat_inc(misroute_cnt);
    end
  end
`endif

endmodule
